// File: rtl/neureka_tcdm_responder.sv
// neureka_tcdm_responder
// Memory-side responder for MP word-interleaved 32-bit TCDM ports.
// Each port maps onto one of MP single-cycle banks selected by the word
// address modulo MP. When two in-range requests hit the same bank, the
// lower-indexed port wins. An LFSR-driven stall generator can throttle
// grants, either per port or for all ports together. The lockstep mode
// exercises a wrapper that ANDs the per-port handshakes.
// Responses return exactly one cycle after the grant and are never
// back-pressured.

module neureka_tcdm_responder #(
    parameter int          MP        = 4,
    parameter int          MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       stall_mode_i,
    input  logic [MP-1:0]    tcdm_req,
    output logic [MP-1:0]    tcdm_gnt,
    input  logic [MP*32-1:0] tcdm_add,
    input  logic [MP-1:0]    tcdm_wen,
    input  logic [MP*4-1:0]  tcdm_be,
    input  logic [MP*32-1:0] tcdm_data,
    output logic [MP*32-1:0] tcdm_r_data,
    output logic [MP-1:0]    tcdm_r_valid,
    output logic             tcdm_r_opc,
    output logic [15:0]      err_cnt_o
);

    localparam int BANK_W = (MP > 1) ? $clog2(MP) : 1;
    localparam int ROWS   = MEM_WORDS / MP;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

    // Advance the 16-bit Fibonacci LFSR (taps 16,14,13,11) by one step.
    // This is the right-shift form: bit 0 is the oldest bit and the
    // feedback enters at bit 15.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic fb;
        fb = cur[0] ^ cur[2] ^ cur[3] ^ cur[5];
        return {fb, cur[15:1]};
    endfunction

    // Apply a byte-enable mask: take bytes from nw where be is set,
    // otherwise keep the bytes of old.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] nw,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            res[k*8 +: 8] = be[k] ? nw[k*8 +: 8] : old[k*8 +: 8];
        end
        return res;
    endfunction

    logic [15:0]       lfsr_r;
    logic [MP-1:0]     stall_s;
    logic [MP-1:0]     active_s;
    logic [MP-1:0]     in_range_s;
    logic [MP-1:0]     conflict_s;
    logic [MP-1:0]     gnt_s;
    logic [29:0]       word_s [MP];
    logic [BANK_W-1:0] bank_s [MP];
    logic [ROW_W-1:0]  row_s  [MP];

    logic              bank_we_s    [MP];
    logic [ROW_W-1:0]  bank_row_s   [MP];
    logic [31:0]       bank_wdata_s [MP];
    logic [3:0]        bank_be_s    [MP];

    logic [31:0]       mem_r [MP][ROWS];

    logic [MP-1:0]     r_valid_r;
    logic [MP*32-1:0]  r_data_r;
    logic              r_opc_r;
    logic [15:0]       err_cnt_r;
    logic [16:0]       err_sum_s;

    // Decode each port's byte address into bank, row and range flag.
    // Addresses below the base wrap to a huge word index, so they are
    // rejected by the explicit base comparison as well.
    always_comb begin
        for (int i = 0; i < MP; i++) begin
            word_s[i]     = 30'((tcdm_add[i*32 +: 32] - BASE_ADDR) >> 2);
            in_range_s[i] = (tcdm_add[i*32 +: 32] >= BASE_ADDR) &&
                            ({2'b00, word_s[i]} < 32'(MEM_WORDS));
            bank_s[i]     = word_s[i][BANK_W-1:0];
            row_s[i]      = word_s[i][BANK_W +: ROW_W];
        end
    end

    // Select the stall pattern from the LFSR state at the start of the cycle.
    always_comb begin
        stall_s = {MP{1'b0}};
        case (stall_mode_i)
            2'd1: begin
                for (int i = 0; i < MP; i++) begin
                    stall_s[i] = lfsr_r[i % 16] & lfsr_r[(i + MP) % 16];
                end
            end
            2'd2: begin
                stall_s = {MP{lfsr_r[0] & lfsr_r[1]}};
            end
            default: begin
                stall_s = {MP{1'b0}};
            end
        endcase
    end

    // Grant logic: an in-range request loses its bank to any lower-indexed
    // active in-range request to the same bank. Out-of-range requests
    // neither block nor get blocked.
    always_comb begin
        active_s = tcdm_req & ~stall_s;
        for (int i = 0; i < MP; i++) begin
            conflict_s[i] = 1'b0;
            for (int j = 0; j < MP; j++) begin
                conflict_s[i] = conflict_s[i] |
                                ((j < i) && active_s[j] && in_range_s[j] &&
                                 in_range_s[i] && (bank_s[j] == bank_s[i]));
            end
        end
        gnt_s = active_s & ~conflict_s;
    end

    assign tcdm_gnt = gnt_s;

    // Route the single granted in-range write (if any) onto each bank's
    // write port. The grant logic guarantees at most one per bank.
    always_comb begin
        for (int b = 0; b < MP; b++) begin
            bank_we_s[b]    = 1'b0;
            bank_row_s[b]   = {ROW_W{1'b0}};
            bank_wdata_s[b] = 32'h0;
            bank_be_s[b]    = 4'h0;
            for (int i = 0; i < MP; i++) begin
                if (gnt_s[i] && in_range_s[i] && !tcdm_wen[i] &&
                    (bank_s[i] == BANK_W'(b))) begin
                    bank_we_s[b]    = 1'b1;
                    bank_row_s[b]   = row_s[i];
                    bank_wdata_s[b] = tcdm_data[i*32 +: 32];
                    bank_be_s[b]    = tcdm_be[i*4 +: 4];
                end else begin
                    bank_we_s[b]    = bank_we_s[b];
                end
            end
        end
    end

    // Bank storage: byte-masked writes, not reset, suppressed during reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < MP; b++) begin
            if (bank_we_s[b] && !rst_i) begin
                mem_r[b][bank_row_s[b]] <= merge_bytes(mem_r[b][bank_row_s[b]],
                                                       bank_wdata_s[b],
                                                       bank_be_s[b]);
            end
        end
    end

    // Saturating sum of the error count plus this cycle's out-of-range grants.
    always_comb begin
        err_sum_s = {1'b0, err_cnt_r};
        for (int i = 0; i < MP; i++) begin
            err_sum_s = err_sum_s + {16'h0000, gnt_s[i] & ~in_range_s[i]};
        end
    end

    // Stall LFSR: free-running, restarts from the seed on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    // Response pipeline: one cycle after a grant, report valid, read data
    // (old contents, sampled before the same-edge write), the
    // out-of-range opcode and the error count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid_r <= {MP{1'b0}};
            r_data_r  <= {(MP*32){1'b0}};
            r_opc_r   <= 1'b0;
            err_cnt_r <= 16'h0000;
        end else begin
            r_valid_r <= gnt_s;
            r_opc_r   <= |(gnt_s & ~in_range_s);
            for (int i = 0; i < MP; i++) begin
                if (gnt_s[i] && tcdm_wen[i]) begin
                    r_data_r[i*32 +: 32] <= in_range_s[i] ? mem_r[bank_s[i]][row_s[i]]
                                                          : 32'hDEAD_BEEF;
                end else begin
                    r_data_r[i*32 +: 32] <= 32'h0000_0000;
                end
            end
            if (err_sum_s[16]) begin
                err_cnt_r <= 16'hFFFF;
            end else begin
                err_cnt_r <= err_sum_s[15:0];
            end
        end
    end

    assign tcdm_r_valid = r_valid_r;
    assign tcdm_r_data  = r_data_r;
    assign tcdm_r_opc   = r_opc_r;
    assign err_cnt_o    = err_cnt_r;

endmodule

// File: tb/tb_neureka_tcdm_responder.sv
// Scoreboard bench for neureka_tcdm_responder (MP = 4).
// The stimulus process checks grants and pushes expected responses.
// A separate negedge monitor pops the expected responses and compares
// them with r_valid, r_data and r_opc.

module tb_neureka_tcdm_responder;

    localparam int MP = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     mode;
    logic [3:0]     req;
    logic [3:0]     gnt;
    logic [127:0]   add;
    logic [3:0]     wen;
    logic [15:0]    be;
    logic [127:0]   data;
    logic [127:0]   r_data;
    logic [3:0]     r_valid;
    logic           r_opc;
    logic [15:0]    err_cnt;

    neureka_tcdm_responder #(
        .MP(MP), .MEM_WORDS(4096), .BASE_ADDR(32'h1000_0000), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .stall_mode_i(mode),
        .tcdm_req(req), .tcdm_gnt(gnt), .tcdm_add(add), .tcdm_wen(wen),
        .tcdm_be(be), .tcdm_data(data), .tcdm_r_data(r_data),
        .tcdm_r_valid(r_valid), .tcdm_r_opc(r_opc), .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        opc;
        int          due;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   gcount   = 0;
    logic [15:0] m;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference stall LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1.
    always @(posedge clk or posedge rst) begin
        if (rst) m <= 16'hACE1;
        else     m <= {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
    end

    function automatic logic [3:0] exp_stall(input logic [1:0] md, input logic [15:0] s);
        logic [3:0] st;
        st = 4'h0;
        case (md)
            2'd1: for (int i = 0; i < 4; i++) st[i] = s[i] & s[i+4];
            2'd2: st = {4{s[0] & s[1]}};
            default: st = 4'h0;
        endcase
        return st;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive one request cycle (entered just after a posedge), check grant,
    // and push expected responses for the expected grants.
    task automatic step(input logic [3:0] r, input logic [127:0] a, input logic [3:0] w,
                        input logic [15:0] b, input logic [127:0] d,
                        input logic [3:0] egnt, input logic [127:0] erd, input logic eopc);
        exp_t e;
        req = r; add = a; wen = w; be = b; data = d;
        @(negedge clk);
        check("gnt", {124'h0, gnt}, {124'h0, egnt});
        for (int i = 0; i < 4; i++) begin
            if (egnt[i]) begin
                e.port = i;
                e.data = w[i] ? erd[i*32 +: 32] : 32'h0;
                e.opc  = eopc;
                e.due  = cyc + 1;
                q.push_back(e);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(4'h0, 128'h0, 4'h0, 16'h0, 128'h0, 4'h0, 128'h0, 1'b0);
    endtask

    // Streaming read of words 4..7 (one per bank); the grant is predicted
    // from the reference LFSR for the current mode.
    task automatic stream_cycle();
        logic [3:0] eg;
        exp_t e;
        req  = 4'hF; wen = 4'hF; be = 16'h0; data = 128'h0;
        add  = {32'h1000_001C, 32'h1000_0018, 32'h1000_0014, 32'h1000_0010};
        @(negedge clk);
        eg = ~exp_stall(mode, m);
        check("stream_gnt", {124'h0, gnt}, {124'h0, eg});
        if (mode == 2'd2 && gnt == 4'hF) gcount++;
        for (int i = 0; i < 4; i++) begin
            if (eg[i]) begin
                e.port = i;
                e.data = 32'hC000_0004 + 32'(i);
                e.opc  = 1'b0;
                e.due  = cyc + 1;
                q.push_back(e);
            end
        end
        @(posedge clk); #1;
    endtask

    // Monitor: pop the responses due in this cycle and compare them.
    always @(negedge clk) begin
        exp_t        e;
        logic [3:0]   ev;
        logic [127:0] ed;
        logic         eo;
        ev = 4'h0; ed = 128'h0; eo = 1'b0;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            if (e.due < cyc) begin
                check("stale_entry", 128'(e.due), 128'(cyc));
            end else begin
                ev[e.port] = 1'b1;
                ed[e.port*32 +: 32] = e.data;
                eo = eo | e.opc;
            end
        end
        check("r_valid", {124'h0, r_valid}, {124'h0, ev});
        for (int i = 0; i < 4; i++) begin
            if (ev[i]) check("r_data", {96'h0, r_data[i*32 +: 32]}, {96'h0, ed[i*32 +: 32]});
        end
        check("r_opc", {127'h0, r_opc}, {127'h0, eo});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; mode = 2'd0; req = 4'h0; add = 128'h0; wen = 4'h0; be = 16'h0; data = 128'h0;
        #2;
        check("reset_r_valid", {124'h0, r_valid}, 128'h0);
        check("reset_r_data", r_data, 128'h0);
        check("reset_r_opc", {127'h0, r_opc}, 128'h0);
        check("reset_err_cnt", {112'h0, err_cnt}, 128'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // single write then readback on port 0
        step(4'b0001, {96'h0, 32'h1000_0000}, 4'b0000, 16'h000F, {96'h0, 32'hCAFE_F00D},
             4'b0001, 128'h0, 1'b0);
        step(4'b0001, {96'h0, 32'h1000_0000}, 4'b0001, 16'h0000, 128'h0,
             4'b0001, {96'h0, 32'hCAFE_F00D}, 1'b0);
        // wrapper-aligned four-port write and read of words 0..3
        step(4'hF, {32'h1000_000C, 32'h1000_0008, 32'h1000_0004, 32'h1000_0000}, 4'h0, 16'hFFFF,
             {32'h0A00_0003, 32'h0A00_0002, 32'h0A00_0001, 32'h0A00_0000}, 4'hF, 128'h0, 1'b0);
        step(4'hF, {32'h1000_000C, 32'h1000_0008, 32'h1000_0004, 32'h1000_0000}, 4'hF, 16'h0,
             128'h0, 4'hF, {32'h0A00_0003, 32'h0A00_0002, 32'h0A00_0001, 32'h0A00_0000}, 1'b0);
        // bank-0 conflict between ports 0 and 2
        step(4'b0001, {96'h0, 32'h1000_0010}, 4'b0000, 16'h000F, {96'h0, 32'h4444_4444},
             4'b0001, 128'h0, 1'b0);
        step(4'b0101, {32'h0, 32'h1000_0010, 32'h0, 32'h1000_0000}, 4'b0101, 16'h0, 128'h0,
             4'b0001, {96'h0, 32'h0A00_0000}, 1'b0);
        step(4'b0100, {32'h0, 32'h1000_0010, 32'h0, 32'h1000_0000}, 4'b0101, 16'h0, 128'h0,
             4'b0100, {32'h0, 32'h4444_4444, 64'h0}, 1'b0);
        // bank-1 write conflict between ports 1 and 3
        step(4'b1110, {32'h1000_0014, 32'h1000_0008, 32'h1000_0004, 32'h0}, 4'b0000, 16'hFFF0,
             {32'h7777_7777, 32'h6666_6666, 32'h5555_5555, 32'h0}, 4'b0110, 128'h0, 1'b0);
        step(4'b1000, {32'h1000_0014, 32'h1000_0008, 32'h1000_0004, 32'h0}, 4'b0000, 16'hFFF0,
             {32'h7777_7777, 32'h6666_6666, 32'h5555_5555, 32'h0}, 4'b1000, 128'h0, 1'b0);
        step(4'b0011, {64'h0, 32'h1000_0008, 32'h1000_0004}, 4'b0011, 16'h0, 128'h0,
             4'b0011, {64'h0, 32'h6666_6666, 32'h5555_5555}, 1'b0);
        step(4'b1000, {32'h1000_0014, 96'h0}, 4'b1000, 16'h0, 128'h0,
             4'b1000, {32'h7777_7777, 96'h0}, 1'b0);
        // partial write, plus the last in-range word
        step(4'b1001, {32'h1000_3FFC, 64'h0, 32'h1000_0020}, 4'b0000, 16'hF00F,
             {32'h3FFC_3FFC, 64'h0, 32'hFFFF_FFFF}, 4'b1001, 128'h0, 1'b0);
        step(4'b0001, {96'h0, 32'h1000_0020}, 4'b0000, 16'h0002, {96'h0, 32'h0000_AB00},
             4'b0001, 128'h0, 1'b0);
        step(4'b1001, {32'h1000_3FFC, 64'h0, 32'h1000_0020}, 4'b1001, 16'h0, 128'h0,
             4'b1001, {32'h3FFC_3FFC, 64'h0, 32'hFFFF_ABFF}, 1'b0);
        // out-of-range read below base
        step(4'b0001, 128'h0, 4'b0001, 16'h0, 128'h0, 4'b0001, {96'h0, 32'hDEAD_BEEF}, 1'b1);
        idle();
        check("err_cnt_after_oor_read", {112'h0, err_cnt}, 128'd1);
        // out-of-range write past the end (aliases bank 0 row 0 if not dropped)
        // shares bank 0 with an in-range read and must not conflict with it
        step(4'b0011, {64'h0, 32'h1000_4000, 32'h1000_0000}, 4'b0001, 16'h00F0,
             {64'h0, 32'hBAD0_BAD0, 32'h0}, 4'b0011, {96'h0, 32'h0A00_0000}, 1'b1);
        step(4'b0001, {96'h0, 32'h1000_0000}, 4'b0001, 16'h0, 128'h0,
             4'b0001, {96'h0, 32'h0A00_0000}, 1'b0);
        check("err_cnt_after_oor_write", {112'h0, err_cnt}, 128'd2);

        // preload words 4..7 for the streaming phase
        step(4'hF, {32'h1000_001C, 32'h1000_0018, 32'h1000_0014, 32'h1000_0010}, 4'h0, 16'hFFFF,
             {32'hC000_0007, 32'hC000_0006, 32'hC000_0005, 32'hC000_0004}, 4'hF, 128'h0, 1'b0);
        mode = 2'd3;
        for (int n = 0; n < 5; n++) stream_cycle();
        mode = 2'd1;
        for (int n = 0; n < 40; n++) stream_cycle();
        mode = 2'd2;
        for (int n = 0; n < 500; n++) stream_cycle();

        // mid-stream reset: the in-flight response is discarded
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        check("rst_r_valid", {124'h0, r_valid}, 128'h0);
        check("rst_err_cnt", {112'h0, err_cnt}, 128'h0);
        check("rst_gnt_seed", {124'h0, gnt}, {124'h0, 4'hF});
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 500; n++) stream_cycle();
        checks++;
        if (gcount < 650 || gcount > 850) begin
            failures++;
            $display("FAIL grant_fraction actual=%0d expected=650..850 of 1000", gcount);
        end

        mode = 2'd0;
        idle(); idle(); idle();
        check("queue_drained", 128'(q.size()), 128'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
